// File: rtl/gf163_inverter.sv
// Multiplicative inverse in GF(2^163), f(z) = z^163 + z^7 + z^6 + z^3 + 1.
// Binary extended Euclid, one reduction step per clock, start/done handshake.
module gf163_inverter #(
   parameter int         M      = 163,
   parameter logic [M:0] F_POLY = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [M-1:0] INV_A,
   output logic [M-1:0] INV_R,
   output logic         DONE,
   output logic         BUSY,
   output logic         ERR
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [M-1:0] F_LOW   = F_POLY[M-1:0];
   localparam logic [M-1:0] TOP_BIT = {1'b1, {(M-1){1'b0}}};
   localparam logic [M:0]   ONE_U   = {{M{1'b0}}, 1'b1};
   localparam logic [M-1:0] ONE_G   = {{(M-1){1'b0}}, 1'b1};

   state_t       r_state, w_state_next;
   logic [M:0]   r_u, w_u_next;
   logic [M:0]   r_v, w_v_next;
   logic [M-1:0] r_g1, w_g1_next;
   logic [M-1:0] r_g2, w_g2_next;
   logic [M-1:0] r_res, w_res_next;
   logic         r_done, w_done_next;
   logic         r_busy, w_busy_next;
   logic         r_err, w_err_next;

   logic         w_a_zero;
   logic         w_u_one;
   logic         w_v_one;
   logic         w_u_gt_v;

   // Multiply by z^-1 mod f: an odd g gets f added first so the shift is exact.
   function automatic logic [M-1:0] f_halve(input logic [M-1:0] g);
      logic [M-1:0] t;
      if (g[0] == 1'b0) begin
         t = g >> 1;
      end else begin
         t = ((g ^ F_LOW) >> 1) | TOP_BIT;
      end
      return t;
   endfunction

   assign w_a_zero = (INV_A == '0);
   assign w_u_one  = (r_u == ONE_U);
   assign w_v_one  = (r_v == ONE_U);
   assign w_u_gt_v = (r_u > r_v);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_u    <= '0;
         r_v    <= '0;
         r_g1   <= '0;
         r_g2   <= '0;
         r_res  <= '0;
         r_done <= 1'b0;
         r_busy <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_u    <= w_u_next;
         r_v    <= w_v_next;
         r_g1   <= w_g1_next;
         r_g2   <= w_g2_next;
         r_res  <= w_res_next;
         r_done <= w_done_next;
         r_busy <= w_busy_next;
         r_err  <= w_err_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_u_next     = r_u;
      w_v_next     = r_v;
      w_g1_next    = r_g1;
      w_g2_next    = r_g2;
      w_res_next   = r_res;
      w_done_next  = 1'b0;
      w_busy_next  = r_busy;
      w_err_next   = r_err;

      case (r_state)
         S_IDLE: begin
            if (START) begin
               if (w_a_zero) begin
                  w_done_next = 1'b1;
                  w_err_next  = 1'b1;
                  w_res_next  = '0;
               end else begin
                  w_u_next     = {1'b0, INV_A};
                  w_v_next     = F_POLY;
                  w_g1_next    = ONE_G;
                  w_g2_next    = '0;
                  w_busy_next  = 1'b1;
                  w_err_next   = 1'b0;
                  w_state_next = S_RUN;
               end
            end
         end

         S_RUN: begin
            // Invariants: g1*a == u and g2*a == v (mod f).
            if (w_u_one) begin
               w_res_next   = r_g1;
               w_done_next  = 1'b1;
               w_busy_next  = 1'b0;
               w_state_next = S_IDLE;
            end else if (w_v_one) begin
               w_res_next   = r_g2;
               w_done_next  = 1'b1;
               w_busy_next  = 1'b0;
               w_state_next = S_IDLE;
            end else if (r_u[0] == 1'b0) begin
               w_u_next  = r_u >> 1;
               w_g1_next = f_halve(r_g1);
            end else if (r_v[0] == 1'b0) begin
               w_v_next  = r_v >> 1;
               w_g2_next = f_halve(r_g2);
            end else if (w_u_gt_v) begin
               w_u_next  = r_u ^ r_v;
               w_g1_next = r_g1 ^ r_g2;
            end else begin
               w_v_next  = r_v ^ r_u;
               w_g2_next = r_g2 ^ r_g1;
            end
         end

         default: begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   assign INV_R = r_res;
   assign DONE  = r_done;
   assign BUSY  = r_busy;
   assign ERR   = r_err;

endmodule

// File: tb/tb_gf163_inverter.sv
// Directed and random checks of gf163_inverter against a bit-serial GF(2^163) multiplier model.
module tb_gf163_inverter;

   localparam int M = 163;
   localparam logic [M:0] F_POLY = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9;
   localparam int LIMIT = 4 * M + 2;

   typedef logic [M:0] vec_t;

   logic         CLK;
   logic         RST;
   logic         START;
   logic [M-1:0] INV_A;
   logic [M-1:0] INV_R;
   logic         DONE;
   logic         BUSY;
   logic         ERR;

   int n_vec  = 0;
   int n_miss = 0;

   logic [M-1:0] res;
   logic         err_o;
   logic         done_seen;
   logic         busy_at_done;
   logic         first_busy;
   int           lat;
   int           busy_cnt;

   gf163_inverter #(.M(M), .F_POLY(F_POLY)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .INV_A (INV_A),
      .INV_R (INV_R),
      .DONE  (DONE),
      .BUSY  (BUSY),
      .ERR   (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input vec_t obs, input vec_t exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Horner-style multiply with reduction by f after every shift.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M:0] r;
      r = '0;
      for (int i = M - 1; i >= 0; i--) begin
         r = {r[M-1:0], 1'b0};
         if (r[M]) r = r ^ F_POLY;
         if (b[i]) r = r ^ {1'b0, a};
      end
      return r[M-1:0];
   endfunction

   function automatic logic [M-1:0] rnd163();
      logic [191:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[M-1:0];
   endfunction

   // Called at a negedge; drives START/INV_A at once and returns at the negedge DONE is seen.
   task automatic do_inv(input logic [M-1:0] a, input bit hold);
      START        = 1'b1;
      INV_A        = a;
      lat          = 0;
      busy_cnt     = 0;
      done_seen    = 1'b0;
      busy_at_done = 1'b1;
      first_busy   = 1'b0;
      res          = '0;
      err_o        = 1'b0;
      while (!done_seen && lat < LIMIT) begin
         @(negedge CLK);
         if (!hold) START = 1'b0;
         lat++;
         if (lat == 1) first_busy = BUSY;
         if (BUSY) busy_cnt++;
         if (DONE) begin
            done_seen    = 1'b1;
            res          = INV_R;
            err_o        = ERR;
            busy_at_done = BUSY;
         end else if (hold) begin
            INV_A = rnd163();
         end
      end
      chk("done_within_limit", vec_t'(done_seen), vec_t'(1));
   endtask

   task automatic check_inverse(input string tag, input logic [M-1:0] a);
      chk({tag, "_prod"}, vec_t'(gf_mul(res, a)), vec_t'(1));
      chk({tag, "_err"}, vec_t'(err_o), vec_t'(0));
      chk({tag, "_busy_at_done"}, vec_t'(busy_at_done), vec_t'(0));
   endtask

   initial begin
      logic [M-1:0] a;
      logic [M-1:0] a2;
      logic [M-1:0] specials [5];
      logic         saw_done;

      RST   = 1'b1;
      START = 1'b0;
      INV_A = '0;
      repeat (3) @(negedge CLK);
      chk("rst_inv_r", vec_t'(INV_R), vec_t'(0));
      chk("rst_done", vec_t'(DONE), vec_t'(0));
      chk("rst_busy", vec_t'(BUSY), vec_t'(0));
      chk("rst_err", vec_t'(ERR), vec_t'(0));
      RST = 1'b0;
      @(negedge CLK);

      // a = 1: two-cycle latency, one busy cycle
      do_inv(163'd1, 1'b0);
      chk("one_lat", vec_t'(lat), vec_t'(2));
      chk("one_res", vec_t'(res), vec_t'(1));
      chk("one_err", vec_t'(err_o), vec_t'(0));
      chk("one_busy_cycles", vec_t'(busy_cnt), vec_t'(1));
      @(negedge CLK);
      chk("one_done_pulse", vec_t'(DONE), vec_t'(0));

      // a = z: inverse is z^162 + z^6 + z^5 + z^2
      do_inv(163'd2, 1'b0);
      a = '0;
      a[M-1] = 1'b1;
      a[7:0] = 8'h64;
      chk("z_res", vec_t'(res), vec_t'(a));
      chk("z_err", vec_t'(err_o), vec_t'(0));
      @(negedge CLK);

      // a = 0: error, immediate DONE, no busy
      do_inv('0, 1'b0);
      chk("zero_lat", vec_t'(lat), vec_t'(1));
      chk("zero_err", vec_t'(err_o), vec_t'(1));
      chk("zero_res", vec_t'(res), vec_t'(0));
      chk("zero_busy_cycles", vec_t'(busy_cnt), vec_t'(0));
      @(negedge CLK);
      chk("zero_done_pulse", vec_t'(DONE), vec_t'(0));
      chk("zero_err_hold", vec_t'(ERR), vec_t'(1));

      // ERR clears on the next accepted nonzero operand
      do_inv(163'd3, 1'b0);
      check_inverse("three", 163'd3);
      @(negedge CLK);

      specials[0] = {1'b1, {(M-1){1'b0}}};
      specials[1] = '1;
      specials[2] = F_POLY[M-1:0];
      specials[3] = 163'h5;
      specials[4] = {1'b1, {(M-2){1'b0}}, 1'b1};
      for (int i = 0; i < 5; i++) begin
         do_inv(specials[i], 1'b0);
         check_inverse("special", specials[i]);
         @(negedge CLK);
         chk("special_done_pulse", vec_t'(DONE), vec_t'(0));
      end

      for (int i = 0; i < 100; i++) begin
         a = rnd163();
         if (a == '0) a = 163'd1;
         do_inv(a, 1'b0);
         check_inverse("rand", a);
         @(negedge CLK);
         chk("rand_done_pulse", vec_t'(DONE), vec_t'(0));
      end

      // START held high with INV_A scrambled mid-run, then back-to-back START
      a  = rnd163() | 163'd1;
      a2 = rnd163() | 163'd2;
      do_inv(a, 1'b1);
      check_inverse("hold", a);
      do_inv(a2, 1'b0);
      chk("b2b_accepted", vec_t'(first_busy), vec_t'(1));
      check_inverse("b2b", a2);
      @(negedge CLK);

      // reset in the middle of a run
      a = rnd163() | {1'b1, {(M-1){1'b0}}};
      START = 1'b1;
      INV_A = a;
      @(negedge CLK);
      START = 1'b0;
      repeat (5) @(negedge CLK);
      chk("pre_rst_busy", vec_t'(BUSY), vec_t'(1));
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("mid_rst_busy", vec_t'(BUSY), vec_t'(0));
      chk("mid_rst_done", vec_t'(DONE), vec_t'(0));
      chk("mid_rst_inv_r", vec_t'(INV_R), vec_t'(0));
      chk("mid_rst_err", vec_t'(ERR), vec_t'(0));
      saw_done = 1'b0;
      repeat (LIMIT) begin
         @(negedge CLK);
         if (DONE || BUSY) saw_done = 1'b1;
      end
      chk("no_activity_after_rst", vec_t'(saw_done), vec_t'(0));

      do_inv(163'd2, 1'b0);
      a = '0;
      a[M-1] = 1'b1;
      a[7:0] = 8'h64;
      chk("post_rst_z_res", vec_t'(res), vec_t'(a));
      chk("post_rst_z_err", vec_t'(err_o), vec_t'(0));
      @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
